// File: rtl/cache_ctrl_if.sv
// CPU, datapath and physical-memory signals seen by the L1 cache sequencing controller.
// The master modport is the controller's view; slave is the surrounding datapath/CPU/memory.
interface cache_ctrl_if;
  logic       mem_read;
  logic       mem_write;
  logic       mem_resp;
  logic [1:0] hit;
  logic [1:0] dirty;
  logic       lru;
  logic       array_read;
  logic [1:0] load_data;
  logic [1:0] load_tag;
  logic [1:0] load_valid;
  logic [1:0] load_dirty;
  logic       dirty_in;
  logic       load_lru;
  logic       lru_in;
  logic       data_sel;
  logic       addr_sel;
  logic       way_sel;
  logic       pmem_read;
  logic       pmem_write;
  logic       pmem_resp;

  modport master (
    input  mem_read, mem_write, hit, dirty, lru, pmem_resp,
    output mem_resp, array_read, load_data, load_tag, load_valid, load_dirty,
           dirty_in, load_lru, lru_in, data_sel, addr_sel, way_sel,
           pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, hit, dirty, lru, pmem_resp,
    input  mem_resp, array_read, load_data, load_tag, load_valid, load_dirty,
           dirty_in, load_lru, lru_in, data_sel, addr_sel, way_sel,
           pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_ctrl.sv
// Sequencing FSM for a 2-way write-back L1: array read strobes, hit/miss resolution,
// write-back and line-fill over a single physical-memory port.
module cache_ctrl (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.master bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] FETCH     = 3'd3;
  localparam logic [2:0] REFILL    = 3'd4;

  logic [2:0] state;
  logic [2:0] state_next;
  logic       victim;
  logic       hit_way;
  logic [1:0] hit_mask;
  logic [1:0] victim_mask;

  // Way 0 wins when both ways report a hit.
  assign hit_way     = ~bus.hit[0];
  assign hit_mask    = hit_way ? 2'b10 : 2'b01;
  assign victim_mask = victim  ? 2'b10 : 2'b01;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      victim <= 1'b0;
    end else begin
      state <= state_next;
      if (state == LOOKUP && bus.hit == 2'b00)
        victim <= bus.lru;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next     = state;
    bus.mem_resp   = 1'b0;
    bus.array_read = 1'b0;
    bus.load_data  = 2'b00;
    bus.load_tag   = 2'b00;
    bus.load_valid = 2'b00;
    bus.load_dirty = 2'b00;
    bus.dirty_in   = 1'b0;
    bus.load_lru   = 1'b0;
    bus.lru_in     = 1'b0;
    bus.data_sel   = 1'b0;
    bus.addr_sel   = 1'b0;
    bus.way_sel    = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;

    case (state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          bus.array_read = 1'b1;
          state_next     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (bus.hit != 2'b00) begin
          bus.mem_resp = 1'b1;
          bus.load_lru = 1'b1;
          bus.lru_in   = ~hit_way;
          if (bus.mem_write) begin
            bus.load_data  = hit_mask;
            bus.load_dirty = hit_mask;
            bus.dirty_in   = 1'b1;
          end
          state_next = IDLE;
        end else begin
          state_next = bus.dirty[bus.lru] ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        bus.pmem_write = 1'b1;
        bus.addr_sel   = 1'b1;
        bus.way_sel    = victim;
        if (bus.pmem_resp)
          state_next = FETCH;
      end
      FETCH: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.load_data  = victim_mask;
          bus.load_tag   = victim_mask;
          bus.load_valid = victim_mask;
          bus.load_dirty = victim_mask;
          bus.data_sel   = 1'b1;
          state_next     = REFILL;
        end
      end
      REFILL: begin
        bus.array_read = 1'b1;
        state_next     = LOOKUP;
      end
      default: state_next = IDLE;
    endcase

    // A reset cycle must not update any array or complete a CPU request; the pmem
    // request itself drops once the state register has returned to IDLE.
    if (rst) begin
      bus.mem_resp   = 1'b0;
      bus.array_read = 1'b0;
      bus.load_data  = 2'b00;
      bus.load_tag   = 2'b00;
      bus.load_valid = 2'b00;
      bus.load_dirty = 2'b00;
      bus.dirty_in   = 1'b0;
      bus.load_lru   = 1'b0;
      bus.lru_in     = 1'b0;
      bus.data_sel   = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Cycle-by-cycle vector bench for cache_ctrl: per-cycle expected outputs from a table,
// plus a scoreboard of expected mem_resp cycles for each accepted request.
module tb_cache_ctrl;

  typedef struct packed {
    logic       mem_resp;
    logic       array_read;
    logic [1:0] load_data;
    logic [1:0] load_tag;
    logic [1:0] load_valid;
    logic [1:0] load_dirty;
    logic       dirty_in;
    logic       load_lru;
    logic       lru_in;
    logic       data_sel;
    logic       addr_sel;
    logic       way_sel;
    logic       pmem_read;
    logic       pmem_write;
  } outs_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       rd;
    logic       wr;
    logic [1:0] hit;
    logic [1:0] dirty;
    logic       lru;
    logic       presp;
    bit         start;
    int         lat;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];
  int   sb[$];

  cache_ctrl_if bus();

  cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.mem_resp   = bus.mem_resp;
    o.array_read = bus.array_read;
    o.load_data  = bus.load_data;
    o.load_tag   = bus.load_tag;
    o.load_valid = bus.load_valid;
    o.load_dirty = bus.load_dirty;
    o.dirty_in   = bus.dirty_in;
    o.load_lru   = bus.load_lru;
    o.lru_in     = bus.lru_in;
    o.data_sel   = bus.data_sel;
    o.addr_sel   = bus.addr_sel;
    o.way_sel    = bus.way_sel;
    o.pmem_read  = bus.pmem_read;
    o.pmem_write = bus.pmem_write;
    return o;
  endfunction

  function automatic outs_t o_none();
    return '0;
  endfunction

  function automatic outs_t o_req();
    outs_t o = '0;
    o.array_read = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_hit_rd(input logic w);
    outs_t o = '0;
    o.mem_resp = 1'b1;
    o.load_lru = 1'b1;
    o.lru_in   = ~w;
    return o;
  endfunction

  function automatic outs_t o_hit_wr(input logic w);
    outs_t o = o_hit_rd(w);
    o.load_data  = w ? 2'b10 : 2'b01;
    o.load_dirty = w ? 2'b10 : 2'b01;
    o.dirty_in   = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_wb(input logic v);
    outs_t o = '0;
    o.pmem_write = 1'b1;
    o.addr_sel   = 1'b1;
    o.way_sel    = v;
    return o;
  endfunction

  function automatic outs_t o_fetch();
    outs_t o = '0;
    o.pmem_read = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_fill(input logic v);
    outs_t o = o_fetch();
    o.load_data  = v ? 2'b10 : 2'b01;
    o.load_tag   = v ? 2'b10 : 2'b01;
    o.load_valid = v ? 2'b10 : 2'b01;
    o.load_dirty = v ? 2'b10 : 2'b01;
    o.data_sel   = 1'b1;
    return o;
  endfunction

  task automatic add(input string name, input logic r, input logic rd, input logic wr,
                     input logic [1:0] hit, input logic [1:0] dirty, input logic lru,
                     input logic presp, input bit start, input int lat, input outs_t exp);
    vec_t v;
    v.name = name; v.rst = r; v.rd = rd; v.wr = wr; v.hit = hit; v.dirty = dirty;
    v.lru = lru; v.presp = presp; v.start = start; v.lat = lat; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    outs_t got;
    int    due;

    //    name            rst rd wr hit    dirty  lru presp start lat expected
    add("reset",          1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_none());
    add("idle",           0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_none());
    // read hit in way 1
    add("rd_req",         0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, o_req());
    add("rd_hit_w1",      0, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, o_hit_rd(1'b1));
    // write hit in way 0
    add("wr_req",         0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1, o_req());
    add("wr_hit_w0",      0, 0, 1, 2'b01, 2'b00, 0, 0, 0, 0, o_hit_wr(1'b0));
    // back-to-back hits, both-ways hit resolves to way 0
    add("b2b_req0",       0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, o_req());
    add("b2b_hit_both",   0, 1, 0, 2'b11, 2'b00, 0, 0, 0, 0, o_hit_rd(1'b0));
    add("b2b_req1",       0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, o_req());
    add("b2b_hit_w0",     0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, o_hit_rd(1'b0));
    // read and write together behave as a write
    add("rw_req",         0, 1, 1, 2'b00, 2'b00, 0, 0, 1, 1, o_req());
    add("rw_hit_w1",      0, 1, 1, 2'b10, 2'b00, 0, 0, 0, 0, o_hit_wr(1'b1));
    // pmem_resp outside WRITEBACK/FETCH has no effect
    add("idle_presp",     0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, o_none());
    add("idle_after",     0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_none());
    // clean miss, victim way 1, lru toggled during FETCH
    add("cm_req",         0, 1, 0, 2'b00, 2'b00, 1, 0, 1, 7, o_req());
    add("cm_miss",        0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0, o_none());
    add("cm_fetch0",      0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0, o_fetch());
    add("cm_fetch1",      0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_fetch());
    add("cm_fetch2",      0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_fetch());
    add("cm_fill",        0, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0, o_fill(1'b1));
    add("cm_refill",      0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_req());
    add("cm_hit",         0, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0, o_hit_rd(1'b1));
    // dirty write miss, victim way 0
    add("dm_req",         0, 0, 1, 2'b00, 2'b01, 0, 0, 1, 7, o_req());
    add("dm_miss",        0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 0, o_none());
    add("dm_wb0",         0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 0, o_wb(1'b0));
    add("dm_wb_resp",     0, 0, 1, 2'b00, 2'b01, 1, 1, 0, 0, o_wb(1'b0));
    add("dm_fetch",       0, 0, 1, 2'b00, 2'b01, 1, 0, 0, 0, o_fetch());
    add("dm_fill",        0, 0, 1, 2'b00, 2'b01, 1, 1, 0, 0, o_fill(1'b0));
    add("dm_refill",      0, 0, 1, 2'b00, 2'b01, 1, 0, 0, 0, o_req());
    add("dm_hit",         0, 0, 1, 2'b01, 2'b01, 1, 0, 0, 0, o_hit_wr(1'b0));
    // reset during FETCH with a pmem_resp in the reset cycle
    add("rf_req",         0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_req());
    add("rf_miss",        0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_none());
    add("rf_fetch",       0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_fetch());
    add("rf_rst0",        1, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0, o_fetch());
    add("rf_rst1",        1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_none());
    add("rf_idle",        0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_none());
    // reset during WRITEBACK of victim way 1
    add("rw_req2",        0, 0, 1, 2'b00, 2'b10, 1, 0, 0, 0, o_req());
    add("rw_miss",        0, 0, 1, 2'b00, 2'b10, 1, 0, 0, 0, o_none());
    add("rw_wb",          0, 0, 1, 2'b00, 2'b10, 1, 0, 0, 0, o_wb(1'b1));
    add("rw_rst",         1, 0, 1, 2'b00, 2'b10, 1, 1, 0, 0, o_wb(1'b1));
    add("rw_idle",        0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_none());
    // recovery: a normal hit after reset
    add("post_req",       0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 1, o_req());
    add("post_hit",       0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, o_hit_rd(1'b0));
    add("post_idle",      0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, o_none());

    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = 2'b00;
    bus.dirty     = 2'b00;
    bus.lru       = 1'b0;
    bus.pmem_resp = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      bus.mem_read  = vecs[i].rd;
      bus.mem_write = vecs[i].wr;
      bus.hit       = vecs[i].hit;
      bus.dirty     = vecs[i].dirty;
      bus.lru       = vecs[i].lru;
      bus.pmem_resp = vecs[i].presp;
      #2;
      got = sample();
      check(vecs[i].name, 32'(got), 32'(vecs[i].exp));
      check({vecs[i].name, "_pmem_excl"}, 32'(got.pmem_read & got.pmem_write), 32'd0);
      if (vecs[i].start)
        sb.push_back(i + vecs[i].lat);
      if (got.mem_resp) begin
        if (sb.size() == 0) begin
          check({vecs[i].name, "_sb_unexpected_resp"}, 32'd1, 32'd0);
        end else begin
          due = sb.pop_front();
          check({vecs[i].name, "_sb_resp_cycle"}, 32'(i), 32'(due));
        end
      end
    end

    check("sb_outstanding", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
